// File: rtl/bounded_counter.sv
// Run-to-limit event counter: counts 0..limit once per unpaused cycle after a
// start, then pulses done for one cycle. Increment goes through a ripple incrementer.

module incrementer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] x_plus_1
);

  // carry[i] is the carry into bit i; the carry into bit 0 is the +1.
  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_carry
    assign carry[i+1] = x[i] & carry[i];
  end

  assign x_plus_1 = x ^ carry;

endmodule

module bounded_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] limit_q;
  logic             busy_q;
  logic             done_q;

  incrementer #(.WIDTH(WIDTH)) u_inc (
    .x        (count_q),
    .x_plus_1 (count_d)
  );

  // busy/done are registered alongside the state so they always equal
  // (state_q == RUN) and (state_q == DONE) without any input->output path.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            limit_q <= limit;
            count_q <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (count_q == limit_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (!pause) begin
            count_q <= count_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bounded_counter.sv
// Directed bench for bounded_counter: basic runs, limit boundaries, pause,
// abort, ignored starts and reset, with hand-computed expectations.

module tb_bounded_counter;

  localparam int unsigned WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] limit;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_pass   = 0;

  bounded_counter #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .limit (limit),
    .pause (pause),
    .abort (abort),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_state(input string tag, input int exp_count,
                              input logic exp_busy, input logic exp_done);
    check({tag, ".count"}, 32'(count), 32'(exp_count));
    check({tag, ".busy"},  32'(busy),  32'(exp_busy));
    check({tag, ".done"},  32'(done),  32'(exp_done));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; limit = '0; pause = 1'b0; abort = 1'b0;
    tick();
    tick();
    expect_state("reset", 0, 1'b0, 1'b0);
    reset = 1'b0;

    // Basic run to 5: busy for counts 0..5, done with count 5, then idle.
    start = 1'b1; limit = 8'd5;
    tick();
    start = 1'b0; limit = 8'd0;
    for (int i = 0; i <= 5; i++) begin
      expect_state($sformatf("basic.run%0d", i), i, 1'b1, 1'b0);
      tick();
    end
    expect_state("basic.done", 5, 1'b0, 1'b1);
    tick();
    expect_state("basic.idle", 5, 1'b0, 1'b0);

    // limit = 0, started on the first idle cycle after done.
    start = 1'b1; limit = 8'd0;
    tick();
    start = 1'b0;
    expect_state("lim0.run", 0, 1'b1, 1'b0);
    tick();
    expect_state("lim0.done", 0, 1'b0, 1'b1);
    tick();
    expect_state("lim0.idle", 0, 1'b0, 1'b0);

    // limit = 255 reaches all-ones without wrapping.
    start = 1'b1; limit = 8'hFF;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 255; i++) begin
      expect_state($sformatf("lim255.run%0d", i), i, 1'b1, 1'b0);
      tick();
    end
    expect_state("lim255.done", 255, 1'b0, 1'b1);
    tick();
    expect_state("lim255.idle", 255, 1'b0, 1'b0);

    // Pause two cycles at count 1: 0,1,1,1,2,3; pause at limit still finishes.
    start = 1'b1; limit = 8'd3;
    tick();
    start = 1'b0;
    expect_state("pause.c0", 0, 1'b1, 1'b0);
    tick();
    expect_state("pause.c1", 1, 1'b1, 1'b0);
    pause = 1'b1;
    tick();
    expect_state("pause.hold1", 1, 1'b1, 1'b0);
    tick();
    expect_state("pause.hold2", 1, 1'b1, 1'b0);
    pause = 1'b0;
    tick();
    expect_state("pause.c2", 2, 1'b1, 1'b0);
    tick();
    expect_state("pause.c3", 3, 1'b1, 1'b0);
    pause = 1'b1;
    tick();
    expect_state("pause.done", 3, 1'b0, 1'b1);
    pause = 1'b0;
    tick();
    expect_state("pause.idle", 3, 1'b0, 1'b0);

    // Abort at count 4 of a limit-10 run.
    start = 1'b1; limit = 8'd10;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    expect_state("abort.c4", 4, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_state("abort.idle", 4, 1'b0, 1'b0);
    tick();
    expect_state("abort.nodone", 4, 1'b0, 1'b0);

    // Abort in the same cycle count reaches limit: no done pulse.
    start = 1'b1; limit = 8'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    expect_state("abortlim.c2", 2, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_state("abortlim.idle", 2, 1'b0, 1'b0);
    tick();
    expect_state("abortlim.nodone", 2, 1'b0, 1'b0);

    // Starts during RUN and DONE are ignored; limit_q stays 4.
    start = 1'b1; limit = 8'd4;
    tick();
    start = 1'b0;
    tick();
    expect_state("ign.c1", 1, 1'b1, 1'b0);
    start = 1'b1; limit = 8'd2;
    tick();
    start = 1'b0;
    expect_state("ign.c2", 2, 1'b1, 1'b0);
    tick();
    expect_state("ign.c3", 3, 1'b1, 1'b0);
    tick();
    expect_state("ign.c4", 4, 1'b1, 1'b0);
    tick();
    expect_state("ign.done", 4, 1'b0, 1'b1);
    start = 1'b1; limit = 8'd3;
    tick();
    expect_state("ign.idle", 4, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    expect_state("ign.restart", 0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_state($sformatf("ign.run%0d", i), i, 1'b1, 1'b0);
    end
    tick();
    expect_state("ign.done2", 3, 1'b0, 1'b1);
    tick();

    // Reset at count 7 of a limit-20 run.
    start = 1'b1; limit = 8'd20;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    expect_state("rst.c7", 7, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_state("rst.after", 0, 1'b0, 1'b0);
    tick();
    expect_state("rst.idle", 0, 1'b0, 1'b0);

    // Reset concurrent with start keeps the block idle.
    reset = 1'b1; start = 1'b1; limit = 8'd5;
    tick();
    reset = 1'b0; start = 1'b0;
    expect_state("rststart.a", 0, 1'b0, 1'b0);
    tick();
    expect_state("rststart.b", 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
